// File: rtl/multi_ch_timebase.sv
// Shared prescaler producing a one-cycle base_tick, plus NUM_CH independent
// down-counting channel timers with gate, one-shot/periodic mode and done pulse.
module multi_ch_timebase #(
    parameter int CLK_DIV = 50_000_000,
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         ch_start,
    input  logic [NUM_CH-1:0]         ch_stop,
    input  logic [NUM_CH-1:0]         ch_gate,
    input  logic [NUM_CH-1:0]         ch_mode,
    input  logic [NUM_CH*CNT_W-1:0]   ch_period,
    output logic                      base_tick,
    output logic [NUM_CH-1:0]         ch_busy,
    output logic [NUM_CH-1:0]         ch_done,
    output logic [NUM_CH*CNT_W-1:0]   ch_remain
);

    localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    logic [PS_W-1:0]   ps_cnt_q, ps_cnt_d;
    logic              base_tick_q, base_tick_d;

    ch_state_e         state_q  [NUM_CH];
    ch_state_e         state_d  [NUM_CH];
    logic [CNT_W-1:0]  remain_q [NUM_CH];
    logic [CNT_W-1:0]  remain_d [NUM_CH];
    logic [CNT_W-1:0]  period_q [NUM_CH];
    logic [CNT_W-1:0]  period_d [NUM_CH];
    logic [NUM_CH-1:0] mode_q, mode_d;
    logic [NUM_CH-1:0] done_q, done_d;

    // Prescaler: the tick is registered, so it appears the cycle after the
    // counter sits at CLK_DIV-1, giving exactly CLK_DIV cycles between pulses.
    always_comb begin
        ps_cnt_d    = ps_cnt_q + PS_W'(1);
        base_tick_d = 1'b0;
        if (ps_cnt_q == PS_LAST) begin
            ps_cnt_d    = '0;
            base_tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_cnt_q    <= '0;
            base_tick_q <= 1'b0;
        end else begin
            ps_cnt_q    <= ps_cnt_d;
            base_tick_q <= base_tick_d;
        end
    end

    // Channel next-state: stop beats start beats tick, so a stop or restart
    // landing on the expiry cycle swallows that channel's done pulse.
    always_comb begin
        done_d = '0;
        mode_d = mode_q;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i]  = state_q[i];
            remain_d[i] = remain_q[i];
            period_d[i] = period_q[i];
            if (ch_stop[i]) begin
                state_d[i]  = ST_IDLE;
                remain_d[i] = '0;
            end else if (ch_start[i]) begin
                period_d[i] = ch_period[i*CNT_W +: CNT_W];
                mode_d[i]   = ch_mode[i];
                if (ch_period[i*CNT_W +: CNT_W] == '0) begin
                    // Zero-length timer expires immediately.
                    state_d[i]  = ST_IDLE;
                    remain_d[i] = '0;
                    done_d[i]   = 1'b1;
                end else begin
                    state_d[i]  = ST_RUN;
                    remain_d[i] = ch_period[i*CNT_W +: CNT_W];
                end
            end else if (state_q[i] == ST_RUN && base_tick_q && ch_gate[i]) begin
                if (remain_q[i] == ONE) begin
                    done_d[i] = 1'b1;
                    if (mode_q[i]) begin
                        remain_d[i] = period_q[i];
                    end else begin
                        state_d[i]  = ST_IDLE;
                        remain_d[i] = '0;
                    end
                end else begin
                    remain_d[i] = remain_q[i] - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= '0;
            done_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]  <= ST_IDLE;
                remain_q[i] <= '0;
                period_q[i] <= '0;
            end
        end else begin
            mode_q <= mode_d;
            done_q <= done_d;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]  <= state_d[i];
                remain_q[i] <= remain_d[i];
                period_q[i] <= period_d[i];
            end
        end
    end

    always_comb begin
        ch_busy   = '0;
        ch_remain = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_busy[i]                   = (state_q[i] == ST_RUN);
            ch_remain[i*CNT_W +: CNT_W]  = remain_q[i];
        end
    end

    assign base_tick = base_tick_q;
    assign ch_done   = done_q;

endmodule
